// File: rtl/secded_pkg.sv
// Shared types and constants for the extended Hamming (8,4) SECDED decoder.
// Codeword layout: cw[0]=p0, cw[1]=p1, cw[2]=p2, cw[4]=p4, cw[3]=d0, cw[5]=d1, cw[6]=d2, cw[7]=d3.
package secded_pkg;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned SYN_W  = 3;

  typedef logic [CODE_W-1:0] codeword_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SYN_W-1:0]  syndrome_t;

  // Rows 0..2 select the positions feeding syndrome bit k; row 3 is the overall parity.
  localparam logic [3:0][CODE_W-1:0] H = {8'hFF, 8'hF0, 8'hCC, 8'hAA};

  function automatic data_t extract_data(input codeword_t cw);
    return {cw[7], cw[6], cw[5], cw[3]};
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational syndrome and overall-parity generator for one codeword.
module secded_syndrome
  import secded_pkg::*;
(
  input  codeword_t cw,
  output syndrome_t syn,
  output logic      par
);

  always_comb begin
    syn = '0;
    for (int k = 0; k < int'(SYN_W); k++) begin
      syn[k] = ^(cw & H[k]);
    end
    par = ^(cw & H[3]);
  end

endmodule

// File: rtl/secded_decoder.sv
// Two-stage valid/ready SECDED (8,4) decoder: stage 1 holds cw/syndrome/parity, stage 2 the result.
// Optional saturating error counters are built only when SECDED_ERR_CNT_EN is defined.
module secded_decoder
  import secded_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         cw_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         data_out,
  output logic [2:0]         err_pos,
  output logic               sgl_err,
  output logic               dbl_err,
  input  logic               cnt_clr,
  output logic [COUNT_W-1:0] sgl_cnt,
  output logic [COUNT_W-1:0] dbl_cnt
);

  syndrome_t in_syn;
  logic      in_par;

  secded_syndrome u_syndrome (
    .cw  (cw_in),
    .syn (in_syn),
    .par (in_par)
  );

  logic      s1_valid_q;
  codeword_t s1_cw_q;
  syndrome_t s1_syn_q;
  logic      s1_par_q;

  logic      s2_valid_q;
  data_t     s2_data_q;
  syndrome_t s2_pos_q;
  logic      s2_sgl_q;
  logic      s2_dbl_q;

  logic s1_load;
  logic s2_load;

  // A stage may load when empty or when its content leaves downstream this cycle.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = !rst && s1_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_cw_q  <= cw_in;
        s1_syn_q <= in_syn;
        s1_par_q <= in_par;
      end
    end
  end

  codeword_t corr_cw;
  data_t     dec_data;
  logic      dec_sgl;
  logic      dec_dbl;
  logic      unused_corr_bits;

  always_comb begin
    corr_cw = s1_cw_q;
    if (s1_par_q && (s1_syn_q != '0)) begin
      corr_cw[s1_syn_q] = ~corr_cw[s1_syn_q];
    end
    dec_data = extract_data(corr_cw);
    dec_sgl  = s1_par_q;
    dec_dbl  = !s1_par_q && (s1_syn_q != '0);
  end

  // Parity positions never reach the data output once correction is applied.
  assign unused_corr_bits = ^{corr_cw[4], corr_cw[2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_pos_q   <= '0;
      s2_sgl_q   <= 1'b0;
      s2_dbl_q   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= dec_data;
        s2_pos_q  <= s1_syn_q;
        s2_sgl_q  <= dec_sgl;
        s2_dbl_q  <= dec_dbl;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign data_out  = s2_data_q;
  assign err_pos   = s2_pos_q;
  assign sgl_err   = s2_sgl_q;
  assign dbl_err   = s2_dbl_q;

`ifdef SECDED_ERR_CNT_EN
  logic [COUNT_W-1:0] sgl_cnt_q, sgl_cnt_d;
  logic [COUNT_W-1:0] dbl_cnt_q, dbl_cnt_d;
  logic               out_xfer;

  assign out_xfer = s2_valid_q && out_ready;

  // Clear takes priority over a same-cycle increment; both counters saturate at all-ones.
  always_comb begin
    sgl_cnt_d = sgl_cnt_q;
    dbl_cnt_d = dbl_cnt_q;
    if (cnt_clr) begin
      sgl_cnt_d = '0;
      dbl_cnt_d = '0;
    end else if (out_xfer) begin
      if (s2_sgl_q && !(&sgl_cnt_q)) begin
        sgl_cnt_d = sgl_cnt_q + COUNT_W'(1);
      end
      if (s2_dbl_q && !(&dbl_cnt_q)) begin
        dbl_cnt_d = dbl_cnt_q + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sgl_cnt_q <= '0;
      dbl_cnt_q <= '0;
    end else begin
      sgl_cnt_q <= sgl_cnt_d;
      dbl_cnt_q <= dbl_cnt_d;
    end
  end

  assign sgl_cnt = sgl_cnt_q;
  assign dbl_cnt = dbl_cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign sgl_cnt        = '0;
  assign dbl_cnt        = '0;
`endif

endmodule

// File: tb/tb_secded_decoder.sv
// Self-checking bench for secded_decoder against a positional-XOR reference decoder.
// A second instance with COUNT_W=2 shares the stimulus to exercise counter saturation.
module tb_secded_decoder;

  localparam int unsigned CW = 16;
`ifdef SECDED_ERR_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    cw_in;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    data_out;
  logic [2:0]    err_pos;
  logic          sgl_err;
  logic          dbl_err;
  logic          cnt_clr;
  logic [CW-1:0] sgl_cnt;
  logic [CW-1:0] dbl_cnt;

  logic       in_ready_unused2;
  logic       out_valid_unused2;
  logic [3:0] data_out_unused2;
  logic [2:0] err_pos_unused2;
  logic       sgl_err_unused2;
  logic       dbl_err_unused2;
  logic [1:0] sgl_cnt2;
  logic [1:0] dbl_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  secded_decoder #(.COUNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cw_in     (cw_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .err_pos   (err_pos),
    .sgl_err   (sgl_err),
    .dbl_err   (dbl_err),
    .cnt_clr   (cnt_clr),
    .sgl_cnt   (sgl_cnt),
    .dbl_cnt   (dbl_cnt)
  );

  secded_decoder #(.COUNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_unused2),
    .cw_in     (cw_in),
    .out_valid (out_valid_unused2),
    .out_ready (out_ready),
    .data_out  (data_out_unused2),
    .err_pos   (err_pos_unused2),
    .sgl_err   (sgl_err_unused2),
    .dbl_err   (dbl_err_unused2),
    .cnt_clr   (cnt_clr),
    .sgl_cnt   (sgl_cnt2),
    .dbl_cnt   (dbl_cnt2)
  );

  // Reference: syndrome is the XOR of the indices of all set bits; packed as {dbl,sgl,pos,data}.
  function automatic logic [8:0] ref_decode(input logic [7:0] cw);
    int         syn;
    int         ones;
    logic [7:0] fixed;
    logic       sgl;
    logic       dbl;
    syn  = 0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      if (cw[i]) begin
        ones++;
        syn = syn ^ i;
      end
    end
    fixed = cw;
    sgl   = (ones % 2) == 1;
    dbl   = !sgl && (syn != 0);
    if (sgl && syn != 0) fixed[syn] = ~fixed[syn];
    return {dbl, sgl, 3'(syn), fixed[7], fixed[6], fixed[5], fixed[3]};
  endfunction

  function automatic logic [8:0] get_obs();
    return {dbl_err, sgl_err, err_pos, data_out};
  endfunction

  function automatic int sat(input int n, input int max_val);
    return (n > max_val) ? max_val : n;
  endfunction

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    cw_in     = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, sgl_err, dbl_err, err_pos, data_out} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {out_valid, sgl_err, dbl_err, err_pos, data_out});
    end
    checks++;
    if (sgl_cnt !== '0 || dbl_cnt !== '0) begin
      errors++;
      $display("FAIL reset_counters got %0d/%0d want 0/0", sgl_cnt, dbl_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [7:0] vec_cw [11];
    logic [8:0] vec_exp[11];
    vec_cw[0] = 8'hAA; vec_exp[0] = {1'b0, 1'b0, 3'd0, 4'hB};
    vec_cw[1] = 8'h8A; vec_exp[1] = {1'b0, 1'b1, 3'd5, 4'hB};
    vec_cw[2] = 8'hAC; vec_exp[2] = {1'b1, 1'b0, 3'd3, 4'hB};
    for (int b = 0; b < 8; b++) begin
      vec_cw[3+b]  = 8'hAA ^ (8'd1 << b);
      vec_exp[3+b] = {1'b0, 1'b1, 3'(b), 4'hB};
    end
    for (int t = 0; t < 11; t++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      cw_in     = vec_cw[t];
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir_in_ready cw=%h got %b want 1", vec_cw[t], in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir_latency_early cw=%h out_valid=%b want 0", vec_cw[t], out_valid);
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL dir_latency cw=%h out_valid=%b want 1", vec_cw[t], out_valid);
      end
      checks++;
      if (get_obs() !== vec_exp[t]) begin
        errors++;
        $display("FAIL dir_result cw=%h got %b want %b", vec_cw[t], get_obs(), vec_exp[t]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [8:0] q[$];
    logic [8:0] e;
    logic [8:0] prev_obs;
    logic       prev_stall;
    prev_stall = 1'b0;
    prev_obs   = '0;
    @(negedge clk);
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = (cyc < 300) && ($urandom_range(9) < 6);
      cw_in     = 8'($urandom);
      out_ready = (cyc >= 300) || ($urandom_range(9) < 6);
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || get_obs() !== prev_obs) begin
          errors++;
          $display("FAIL rnd_hold cyc=%0d got %b/%b want 1/%b", cyc, out_valid, get_obs(), prev_obs);
        end
      end
      if (in_valid && in_ready) q.push_back(ref_decode(cw_in));
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_spurious cyc=%0d got %b want none", cyc, get_obs());
        end else begin
          e = q.pop_front();
          if (get_obs() !== e) begin
            errors++;
            $display("FAIL rnd_result cyc=%0d got %b want %b", cyc, get_obs(), e);
          end
        end
      end
      if (q.size() > 2) begin
        checks++;
        errors++;
        $display("FAIL rnd_in_flight cyc=%0d got %0d want <=2", cyc, q.size());
      end
      prev_stall = out_valid && !out_ready;
      prev_obs   = get_obs();
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rnd_drain got %0d pending want 0", q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] bp_cw[4];
    logic [8:0] q[$];
    logic [8:0] held;
    logic [8:0] e;
    logic       have_held;
    int         idx;
    int         got;
    bp_cw[0] = 8'hAA; bp_cw[1] = 8'h8A; bp_cw[2] = 8'hAC; bp_cw[3] = 8'h5F;
    idx = 0; got = 0; have_held = 1'b0; held = '0;
    @(negedge clk);
    for (int cyc = 0; cyc < 5; cyc++) begin
      out_ready = 1'b0;
      in_valid  = idx < 4;
      cw_in     = bp_cw[idx % 4];
      #1;
      if (in_valid && in_ready) begin
        q.push_back(ref_decode(cw_in));
        idx++;
      end
      if (out_valid) begin
        if (!have_held) begin
          held      = get_obs();
          have_held = 1'b1;
        end else begin
          checks++;
          if (get_obs() !== held) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d got %b want %b", cyc, get_obs(), held);
          end
        end
      end
      if (cyc == 4) begin
        checks++;
        if (idx != 2) begin
          errors++;
          $display("FAIL bp_accepts got %0d want 2", idx);
        end
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready got %b want 0", in_ready);
        end
      end
      @(negedge clk);
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = 1'b1;
      in_valid  = idx < 4;
      cw_in     = bp_cw[idx % 4];
      #1;
      if (in_valid && in_ready) begin
        q.push_back(ref_decode(cw_in));
        idx++;
      end
      if (out_valid && out_ready) begin
        got++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL bp_spurious got %b want none", get_obs());
        end else begin
          e = q.pop_front();
          if (get_obs() !== e) begin
            errors++;
            $display("FAIL bp_order got %b want %b", get_obs(), e);
          end
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (got != 4 || q.size() != 0) begin
      errors++;
      $display("FAIL bp_count got %0d out %0d pending want 4/0", got, q.size());
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] cw;
    logic [8:0] e;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    cw_in     = 8'h8A;
    @(negedge clk);
    cw_in = 8'hAC;
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (sgl_cnt !== '0 || dbl_cnt !== '0 || sgl_cnt2 !== '0 || dbl_cnt2 !== '0) begin
      errors++;
      $display("FAIL rstmid_counters got %0d/%0d/%0d/%0d want 0", sgl_cnt, dbl_cnt, sgl_cnt2,
               dbl_cnt2);
    end
    rst = 1'b0;
    @(negedge clk);
    cw        = 8'($urandom);
    e         = ref_decode(cw);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cw_in     = cw;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_in_ready got %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ghost got out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || get_obs() !== e) begin
      errors++;
      $display("FAIL rstmid_result got %b/%b want 1/%b", out_valid, get_obs(), e);
    end
    @(negedge clk);
  endtask

  task automatic test_counters();
    logic [7:0] lst[$];
    logic [8:0] e;
    int         n_sgl;
    int         n_dbl;
    int         idx;
    int         got;
    logic       seen;
    n_sgl = 0;
    n_dbl = 0;
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    checks++;
    if (sgl_cnt !== '0 || dbl_cnt !== '0 || sgl_cnt2 !== '0 || dbl_cnt2 !== '0) begin
      errors++;
      $display("FAIL cnt_clear_idle got %0d/%0d/%0d/%0d want 0", sgl_cnt, dbl_cnt, sgl_cnt2,
               dbl_cnt2);
    end
    for (int phase = 0; phase < 2; phase++) begin
      lst.delete();
      if (phase == 0) begin
        lst.push_back(8'h8A); lst.push_back(8'hAC); lst.push_back(8'hAB);
        lst.push_back(8'hA9); lst.push_back(8'hA2);
      end else begin
        for (int k = 0; k < 5; k++) lst.push_back(8'hAA ^ (8'd1 << $urandom_range(7)));
      end
      idx = 0;
      got = 0;
      @(negedge clk);
      for (int cyc = 0; cyc < 40 && got < lst.size(); cyc++) begin
        out_ready = 1'b1;
        in_valid  = idx < lst.size();
        cw_in     = lst[idx % lst.size()];
        #1;
        if (in_valid && in_ready) begin
          e = ref_decode(cw_in);
          n_sgl += int'(e[7]);
          n_dbl += int'(e[8]);
          idx++;
        end
        if (out_valid && out_ready) got++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
      checks++;
      if (got != lst.size()) begin
        errors++;
        $display("FAIL cnt_stream_timeout phase=%0d got %0d want %0d", phase, got, lst.size());
      end
      checks++;
      if (sgl_cnt !== CW'(CntEn ? n_sgl : 0) || dbl_cnt !== CW'(CntEn ? n_dbl : 0)) begin
        errors++;
        $display("FAIL cnt_values phase=%0d got %0d/%0d want %0d/%0d", phase, sgl_cnt, dbl_cnt,
                 CntEn ? n_sgl : 0, CntEn ? n_dbl : 0);
      end
      checks++;
      if (sgl_cnt2 !== 2'(CntEn ? sat(n_sgl, 3) : 0) ||
          dbl_cnt2 !== 2'(CntEn ? sat(n_dbl, 3) : 0)) begin
        errors++;
        $display("FAIL cnt_saturate phase=%0d got %0d/%0d want %0d/%0d", phase, sgl_cnt2,
                 dbl_cnt2, CntEn ? sat(n_sgl, 3) : 0, CntEn ? sat(n_dbl, 3) : 0);
      end
    end
    // Raise cnt_clr exactly in the cycle an error result transfers out.
    seen = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cw_in     = 8'h8A;
    for (int cyc = 0; cyc < 6 && !seen; cyc++) begin
      #1;
      if (out_valid && out_ready) begin
        cnt_clr = 1'b1;
        seen    = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
    cnt_clr = 1'b0;
    #1;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL cnt_clr_timeout got no output want one");
    end
    checks++;
    if (sgl_cnt !== '0 || dbl_cnt !== '0 || sgl_cnt2 !== '0 || dbl_cnt2 !== '0) begin
      errors++;
      $display("FAIL cnt_clr_wins got %0d/%0d/%0d/%0d want 0", sgl_cnt, dbl_cnt, sgl_cnt2,
               dbl_cnt2);
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midstream();
    test_counters();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
